// File: rtl/operand_pkg.sv
// Shared constants, FSM state encoding and shift codes for the operand fetch stage.
package operand_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int RW     = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD_A = 2'b01,
    RD_B = 2'b10,
    HOLD = 2'b11
  } state_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // One-place barrel for the B operand; asr keeps the sign bit.
  function automatic logic [DATA_W-1:0] shift_operand(input logic [DATA_W-1:0] v,
                                                      input logic [1:0]        sh);
    logic [DATA_W-1:0] r;
    case (sh)
      SH_LSL:  r = {v[DATA_W-2:0], 1'b0};
      SH_LSR:  r = {1'b0, v[DATA_W-1:1]};
      SH_ASR:  r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8x16 register file: one write port, one combinational read port, sync reset to zero.
module regfile8x16
  import operand_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RW-1:0]     rd_num,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_num] = wr_data;
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign rd_data = regs_q[rd_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand stage ahead of the ALU: reads Rn then Rm over two cycles, shifts/muxes, hands off.
// Build option OPERAND_BYPASS_EN: a write coinciding with an operand read forwards the new data.
module operand_fetch
  import operand_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RW-1:0]     rn,
  input  logic [RW-1:0]     rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        op_in,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] ain,
  output logic [DATA_W-1:0] bin,
  output logic [1:0]        alu_op,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_num,
  input  logic [DATA_W-1:0] wr_data
);

  state_e            state_q, state_d;
  logic [RW-1:0]     rn_q, rn_d, rm_q, rm_d;
  logic [1:0]        shift_q, shift_d, op_q, op_d;
  logic              asel_q, asel_d, bsel_q, bsel_d;
  logic [DATA_W-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic [RW-1:0]     rd_num;
  logic [DATA_W-1:0] rf_data, rd_val;

  regfile8x16 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_num  (rd_num),
    .rd_data (rf_data)
  );

  assign rd_num = (state_q == RD_B) ? rm_q : rn_q;

`ifdef OPERAND_BYPASS_EN
  assign rd_val = (wr_en && (wr_num == rd_num)) ? wr_data : rf_data;
`else
  assign rd_val = rf_data;
`endif

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    imm_d   = imm_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift;
          asel_d  = asel;
          bsel_d  = bsel;
          imm_d   = imm;
          op_d    = op_in;
          state_d = RD_A;
        end
      end
      RD_A: begin
        a_d     = rd_val;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = rd_val;
        state_d = HOLD;
      end
      HOLD: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign op_valid  = (state_q == HOLD);
  assign ain       = asel_q ? '0 : a_q;
  assign bin       = bsel_q ? imm_q : shift_operand(b_q, shift_q);
  assign alu_op    = op_q;

endmodule
